// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the multi-word UART transmitter.
// Holds the parity mode enum, the TX FSM state enum and the baud divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Nearest-integer clocks per bit.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period tick generator.
// Ports: clk, rst_n (async low), enable (counter cleared when low), tick (1 cycle every DIV clocks).
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);
    import uart_pkg::*;

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_multi.sv
// uart_tx_multi: sends up to NUM_BYTES words from dbuffer back-to-back in one burst.
// Ports: clk, rst_n, tx_start, tx_len, dbuffer in; tx (idle high), tx_busy, tx_done (1-cycle) out.
module uart_tx_multi #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int NUM_BYTES = 3,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    localparam int LW       = $clog2(NUM_BYTES + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tx_start,
    input  logic [LW-1:0]                  tx_len,
    input  logic [NUM_BYTES*DATA_BITS-1:0] dbuffer,
    output logic                           tx,
    output logic                           tx_busy,
    output logic                           tx_done
);
    import uart_pkg::*;

    localparam int             DIV    = calc_div(CLK_FREQ, BAUD);
    localparam int             BW     = $clog2(DATA_BITS);
    localparam logic [LW-1:0]  MAXLEN = LW'(NUM_BYTES);
    localparam parity_e        PMODE  = parity_e'(PARITY[1:0]);

    tx_state_e                      state;
    logic [NUM_BYTES*DATA_BITS-1:0] buf_q;
    logic [DATA_BITS-1:0]           sh;
    logic                           par_q;
    logic [BW-1:0]                  bit_cnt;
    logic                           stop_cnt;
    logic [LW-1:0]                  word_idx;
    logic [LW-1:0]                  len_q;
    logic                           tick;

    uart_baud_gen #(
        .DIV(DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(state != IDLE),
        .tick  (tick)
    );

    function automatic logic par_bit(input logic [DATA_BITS-1:0] w);
        return (PMODE == PAR_ODD) ? ~^w : ^w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            buf_q    <= '0;
            sh       <= '0;
            par_q    <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            word_idx <= '0;
            len_q    <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start && tx_len != '0) begin
                        buf_q    <= dbuffer;
                        len_q    <= (tx_len > MAXLEN) ? MAXLEN : tx_len;
                        word_idx <= '0;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx      <= buf_q[0];
                        sh      <= buf_q[DATA_BITS-1:0] >> 1;
                        par_q   <= par_bit(buf_q[DATA_BITS-1:0]);
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == BW'(DATA_BITS - 1)) begin
                            if (PMODE != PAR_NONE) begin
                                tx    <= par_q;
                                state <= uart_pkg::PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            tx      <= sh[0];
                            sh      <= sh >> 1;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (tick) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (STOP_BITS == 2 && stop_cnt == 1'b0) begin
                            stop_cnt <= 1'b1;
                        end else if (word_idx == len_q - LW'(1)) begin
                            word_idx <= '0;
                            tx_busy  <= 1'b0;
                            tx_done  <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // Next word moves into the low slot; no idle gap.
                            word_idx <= word_idx + LW'(1);
                            buf_q    <= buf_q >> DATA_BITS;
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_multi.sv
// tb_uart_tx_multi: scoreboard bench for uart_tx_multi in 8N1, 8E2 and 8O1 (2-word) builds.
// Stimulus pushes per-cycle expected line/busy/done; a negedge monitor pops and compares.
module tb_uart_tx_multi;

    localparam int DIV = 10;

    typedef struct packed {
        logic [2:0] tx;
        logic [2:0] busy;
        logic [2:0] done;
    } exp_t;

    localparam exp_t IDLE_E = '{tx: 3'b111, busy: 3'b000, done: 3'b000};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1, start2;
    logic [1:0]  tx_len;
    logic [23:0] dbuf;
    logic        tx0, tx1, tx2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    exp_t e_m;
    exp_t g_m;

    always #5 clk = ~clk;

    uart_tx_multi #(
        .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8),
        .NUM_BYTES(3), .PARITY(0), .STOP_BITS(1)
    ) d0 (
        .clk(clk), .rst_n(rst_n), .tx_start(start0), .tx_len(tx_len),
        .dbuffer(dbuf), .tx(tx0), .tx_busy(busy0), .tx_done(done0)
    );

    uart_tx_multi #(
        .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8),
        .NUM_BYTES(3), .PARITY(2), .STOP_BITS(2)
    ) d1 (
        .clk(clk), .rst_n(rst_n), .tx_start(start1), .tx_len(tx_len),
        .dbuffer(dbuf), .tx(tx1), .tx_busy(busy1), .tx_done(done1)
    );

    uart_tx_multi #(
        .CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8),
        .NUM_BYTES(2), .PARITY(1), .STOP_BITS(1)
    ) d2 (
        .clk(clk), .rst_n(rst_n), .tx_start(start2), .tx_len(tx_len),
        .dbuffer(dbuf[15:0]), .tx(tx2), .tx_busy(busy2), .tx_done(done2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            e_m = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_E;
            g_m = '{tx: {tx2, tx1, tx0},
                    busy: {busy2, busy1, busy0},
                    done: {done2, done1, done0}};
            tests++;
            if (g_m !== e_m) begin
                fails++;
                $display("FAIL line cyc=%0d tx/busy/done got %b/%b/%b required %b/%b/%b",
                         cyc, g_m.tx, g_m.busy, g_m.done, e_m.tx, e_m.busy, e_m.done);
            end
        end
    end

    // Reference: frame = start, LSB-first data, optional parity, stop bits;
    // each bit DIV clocks, then one idle cycle carrying the done pulse.
    task automatic push_burst(input int inst, input logic [23:0] b, input int len);
        int   nb;
        int   par;
        int   ns;
        int   l;
        int   ones;
        logic [7:0] word;
        bit   bits[$];
        exp_t e;
        nb  = (inst == 2) ? 2 : 3;
        par = (inst == 1) ? 2 : ((inst == 2) ? 1 : 0);
        ns  = (inst == 1) ? 2 : 1;
        l   = (len > nb) ? nb : len;
        if (l == 0) return;
        for (int w = 0; w < l; w++) begin
            word = b[8*w +: 8];
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(word[i]);
            ones = $countones(word);
            if (par == 2) bits.push_back(ones % 2 == 1);
            if (par == 1) bits.push_back(ones % 2 == 0);
            for (int s = 0; s < ns; s++) bits.push_back(1'b1);
            foreach (bits[k]) begin
                e = IDLE_E;
                e.tx[inst]   = bits[k];
                e.busy[inst] = 1'b1;
                for (int c = 0; c < DIV; c++) exp_q.push_back(e);
            end
        end
        e = IDLE_E;
        e.done[inst] = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic set_start(input int inst, input logic v);
        case (inst)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic send(input int inst, input logic [23:0] b, input int len);
        dbuf   = b;
        tx_len = 2'(len);
        set_start(inst, 1'b1);
        @(posedge clk);
        push_burst(inst, b, len);
        #1;
        set_start(inst, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        tx_len = '0;
        dbuf   = '0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(0, 24'h0000A5, 1);
        drain();
        send(0, 24'h5A3C01, 3);
        drain();
        send(2, 24'h00BEEF, 3);
        drain();
        send(0, 24'h123456, 0);
        repeat (20) @(posedge clk);
        #1;

        send(0, 24'hC0FFEE, 3);
        repeat (37) @(posedge clk);
        for (int r = 0; r < 3; r++) begin
            #1;
            start0 = 1'b1;
            dbuf   = $urandom;
            tx_len = 2'd1;
            @(posedge clk);
            #1;
            start0 = 1'b0;
            repeat (50) @(posedge clk);
        end
        drain();

        dbuf   = 24'h0000A5;
        tx_len = 2'd1;
        start0 = 1'b1;
        @(posedge clk);
        push_burst(0, 24'h0000A5, 1);
        push_burst(0, 24'h77F00E, 3);
        #1;
        dbuf   = 24'h77F00E;
        tx_len = 2'd3;
        n = 0;
        while (!done0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!done0) begin
            fails++;
            $display("FAIL b2b_done: done0 got %b required 1", done0);
        end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        dbuf   = 24'h000000;
        drain();

        send(1, 24'h0000A5, 1);
        drain();
        send(2, 24'h0000A5, 1);
        drain();

        send(0, 24'h00C3A5, 2);
        repeat (44) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        tests++;
        if ({tx0, busy0, done0} !== 3'b100) begin
            fails++;
            $display("FAIL reset_abort: tx/busy/done got %b%b%b required 100",
                     tx0, busy0, done0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 24'h00003C, 1);
        drain();

        for (int i = 0; i < 25; i++) begin
            send($urandom_range(0, 2), 24'($urandom), $urandom_range(0, 3));
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
